// File: rtl/demux1_4_stream.sv
// 1-to-4 stream demultiplexer: routes each accepted word to one of four
// single-entry output buffers, each with its own delivered-word counter.
module demux1_4_stream #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] di,
  input  logic [1:0]   sel,
  input  logic         di_valid,
  output logic         di_ready,
  output logic [n-1:0] do1,
  output logic [n-1:0] do2,
  output logic [n-1:0] do3,
  output logic [n-1:0] do4,
  output logic [3:0]   do_valid,
  input  logic [3:0]   do_ready,
  output logic [31:0]  cnt
);

  // Handshake rule on every port: a transfer happens in a cycle where both
  // valid and ready are 1; valid never drops without a transfer (except reset),
  // and data is held stable while valid=1 and ready=0.

  logic [3:0][n-1:0] data_q;
  logic [3:0]        valid_q;
  logic [3:0][7:0]   cnt_q;
  logic              accept;

  // Only the selected channel matters; a full buffer can refill in the
  // same cycle it drains, giving one word per cycle per channel.
  always_comb begin
    di_ready = 1'b0;
    if (!rst) begin
      di_ready = !valid_q[sel] || do_ready[sel];
    end
  end

  assign accept = di_valid && di_ready;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic load;
    logic hs;

    assign load = accept && (sel == 2'(k));
    assign hs   = valid_q[k] && do_ready[k];

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        cnt_q[k]   <= '0;
      end else begin
        if (load) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= di;
        end else if (hs) begin
          valid_q[k] <= 1'b0;
        end
        if (hs) begin
          cnt_q[k] <= cnt_q[k] + 8'd1;
        end
      end
    end
  end

  assign do1      = data_q[0];
  assign do2      = data_q[1];
  assign do3      = data_q[2];
  assign do4      = data_q[3];
  assign do_valid = valid_q;
  assign cnt      = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_demux1_4_stream.sv
// Bench for demux1_4_stream: directed scenarios plus random traffic, every
// cycle compared against a per-channel queue model of pending words.
module tb_demux1_4_stream;

  logic        clk;
  logic        rst;
  logic [31:0] di;
  logic [1:0]  sel;
  logic        di_valid;
  logic        di_ready;
  logic [31:0] do1, do2, do3, do4;
  logic [3:0]  do_valid;
  logic [3:0]  do_ready;
  logic [31:0] cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: words accepted but not yet delivered, per channel,
  // the value each channel's output shows once empty, and delivery counts.
  logic [31:0] exp_q [4][$];
  logic [31:0] m_hold [4];
  int          m_cnt  [4];

  demux1_4_stream #(.n(32)) dut (
    .clk(clk), .rst(rst), .di(di), .sel(sel), .di_valid(di_valid),
    .di_ready(di_ready), .do1(do1), .do2(do2), .do3(do3), .do4(do4),
    .do_valid(do_valid), .do_ready(do_ready), .cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_ready();
    if (rst) return 1'b0;
    return (exp_q[sel].size() == 0) || do_ready[sel];
  endfunction

  function automatic logic [31:0] m_out(input int k);
    if (exp_q[k].size() != 0) return exp_q[k][0];
    return m_hold[k];
  endfunction

  // One clock cycle: compare everything against the model, advance the model
  // with the current inputs, then move to just after the next rising edge.
  task automatic step();
    logic [3:0]  ev;
    logic [31:0] ec;
    logic        r;
    #1;
    r = m_ready();
    for (int k = 0; k < 4; k++) ev[k] = (exp_q[k].size() != 0);
    ec = {m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]};
    chk("di_ready", di_ready, r);
    chk("do_valid", do_valid, ev);
    chk("do1", do1, m_out(0));
    chk("do2", do2, m_out(1));
    chk("do3", do3, m_out(2));
    chk("do4", do4, m_out(3));
    chk("cnt", cnt, ec);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        exp_q[k].delete();
        m_hold[k] = '0;
        m_cnt[k]  = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (exp_q[k].size() != 0 && do_ready[k]) begin
          m_hold[k] = exp_q[k].pop_front();
          m_cnt[k]  = (m_cnt[k] + 1) % 256;
        end
      end
      if (di_valid && r) exp_q[sel].push_back(di);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                       input logic [3:0] dr);
    di_valid = v;
    sel      = s;
    di       = d;
    do_ready = dr;
  endtask

  logic [31:0] cnt_before;

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_hold[k] = '0;
      m_cnt[k]  = 0;
    end
    rst = 1'b1;
    drive(1'b1, 2'd0, 32'h1234_5678, 4'b0000);
    @(posedge clk);
    #1;
    // Reset state; first step's model starts cleared by rst=1
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 2'd3, 32'h0, 4'b0000);
    step();

    // Single routing to channel 3
    drive(1'b1, 2'd2, 32'hA5A5_0001, 4'b0000);
    step();
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    chk("route_valid", do_valid, 4'b0100);
    chk("route_do3", do3, 32'hA5A5_0001);
    step();
    drive(1'b0, 2'd0, 32'h0, 4'b0100);
    step();

    // Backpressure on channel 1
    drive(1'b1, 2'd0, 32'h0000_0B01, 4'b0000);
    step();
    drive(1'b1, 2'd0, 32'h0000_0B02, 4'b0000);
    #1;
    chk("bp_ready_low", di_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_do1_stable", do1, 32'h0000_0B01);
    end
    drive(1'b1, 2'd0, 32'h0000_0B02, 4'b0001);
    #1;
    chk("bp_ready_high", di_ready, 1'b1);
    step();
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    chk("bp_new_word", do1, 32'h0000_0B02);
    chk("bp_cnt1", cnt[7:0], 8'd1);
    step();
    drive(1'b0, 2'd0, 32'h0, 4'b0001);
    step();

    // Full throughput on channel 2
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'd1, 32'(i), 4'b1111);
      step();
      chk("thru_valid", do_valid[1], 1'b1);
      chk("thru_do2", do2, 32'(i));
    end
    drive(1'b0, 2'd1, 32'h0, 4'b1111);
    step();
    chk("thru_cnt2", cnt[15:8], 8'd8);

    // Counter wrap on channel 4
    cnt_before = cnt;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 2'd3, 32'hC000_0000 + 32'(i), 4'b1000);
      step();
    end
    drive(1'b0, 2'd3, 32'h0, 4'b1000);
    step();
    chk("wrap_cnt4", cnt[31:24], cnt_before[31:24]);
    chk("wrap_others", cnt[23:0], cnt_before[23:0]);

    // Channel isolation: channel 1 stalled, channel 4 still accepts
    drive(1'b1, 2'd0, 32'h0000_1501, 4'b0000);
    step();
    drive(1'b1, 2'd3, 32'h0000_4404, 4'b0000);
    #1;
    chk("iso_ready", di_ready, 1'b1);
    step();
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    chk("iso_valid4", do_valid[3], 1'b1);
    chk("iso_do4", do4, 32'h0000_4404);

    // Reset mid-operation with all channels full
    drive(1'b1, 2'd1, 32'h0000_2222, 4'b0000);
    step();
    drive(1'b1, 2'd2, 32'h0000_3333, 4'b0000);
    step();
    chk("pre_rst_full", do_valid, 4'b1111);
    rst = 1'b1;
    drive(1'b1, 2'd2, 32'h0000_9999, 4'b1111);
    #1;
    chk("rst_ready_low", di_ready, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, 2'd1, 32'h0, 4'b0000);
    #1;
    chk("post_rst_valid", do_valid, 4'b0000);
    chk("post_rst_cnt", cnt, 32'h0);
    chk("post_rst_data", {do1 | do2 | do3 | do4}, 32'h0);
    chk("post_rst_ready", di_ready, 1'b1);
    step();

    // Random traffic, occasional reset
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)));
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1_4_stream.md
DEMUX1_4_STREAM -- requirements
Module: demux1_4_stream

Interface
REQ-001 The block SHALL have parameter n, default 32, giving the data word width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 The block SHALL have port di  input  n  input data word.
REQ-005 The block SHALL have port sel  input  2  destination select: 00->do1, 01->do2, 10->do3, 11->do4.
REQ-006 The block SHALL have port di_valid  input  1  input word and sel are valid this cycle.
REQ-007 The block SHALL have port di_ready  output  1  block accepts the input word this cycle.
REQ-008 The block SHALL have ports do1, do2, do3, do4  output  n each  registered output data, channels 1..4.
REQ-009 The block SHALL have port do_valid  output  4  per-channel output valid; bit k-1 is channel k.
REQ-010 The block SHALL have port do_ready  input  4  per-channel downstream ready; bit k-1 is channel k.
REQ-011 The block SHALL have port cnt  output  32  packed 8-bit per-channel delivered-word counters; cnt[8(k-1)+7:8(k-1)] is channel k.

Function
REQ-012 Each channel SHALL hold a one-entry buffer: an n-bit data register driving dok and a valid flag driving do_valid[k-1].
REQ-013 Input accept SHALL occur in a cycle when di_valid=1 and di_ready=1.
REQ-014 di_ready SHALL be combinational: 1 when rst=0 and the selected channel is empty, or is full and its do_ready bit is 1 in the same cycle.
REQ-015 di_ready SHALL depend only on sel, the selected channel's valid flag and do_ready bit, and rst; other channels' states SHALL have no effect.
REQ-016 On accept, di SHALL be written into the selected channel's data register and its valid flag set at the next rising edge; accept-to-do_valid latency is exactly 1 cycle.
REQ-017 Output handshake on channel k SHALL occur in a cycle when do_valid[k-1]=1 and do_ready[k-1]=1.
REQ-018 On an output handshake with no accept to the same channel, that channel's valid flag SHALL clear at the next edge; its data register SHALL hold its last value.
REQ-019 On an output handshake and an accept to the same channel in the same cycle, the channel SHALL load the new word and keep valid=1; sustained throughput is one word per cycle per channel.
REQ-020 While do_valid[k-1]=1 and do_ready[k-1]=0, dok and do_valid[k-1] SHALL remain stable.
REQ-021 do_valid[k-1] SHALL NOT deassert without an output handshake, except by reset.
REQ-022 With di_valid=0, changes on sel and di SHALL have no effect on any state.
REQ-023 Channels SHALL drain independently; any combination of the four channels may handshake in the same cycle.
REQ-024 Words SHALL be delivered in acceptance order within each channel; no word is dropped or duplicated.
REQ-025 Each 8-bit counter SHALL increment by 1 at the edge following an output handshake on its channel and SHALL wrap from 255 to 0.
REQ-026 The block SHALL contain no combinational path from di to any output.

Reset
REQ-027 When rst=1 at a rising edge, all four valid flags, all four data registers, and all counters SHALL be set to 0.
REQ-028 While rst=1, di_ready SHALL be 0 and no input accept SHALL occur.
REQ-029 Reset SHALL take priority over any simultaneous accept or output handshake; words held in buffers are discarded.
REQ-030 In the first cycle after rst deasserts, di_ready SHALL be 1 for any sel.

Verification
REQ-031 The bench SHALL cover single routing: after reset, di=32'hA5A5_0001, sel=10, di_valid=1 for one cycle, do_ready=0000 -> next cycle do_valid=0100, do3=32'hA5A5_0001, other valids 0.
REQ-032 The bench SHALL cover backpressure: channel 1 full, do_ready=0000, sel=00, di_valid=1 -> di_ready=0; do1 stable for 5 cycles; then do_ready=0001 -> di_ready=1 that cycle, the new word appears on do1 next cycle, cnt[7:0]=1.
REQ-033 The bench SHALL cover full throughput: do_ready=1111, sel=01, 8 consecutive words 1..8 -> do2 presents 1..8 on consecutive cycles, do_valid[1] continuously 1, cnt[15:8]=8.
REQ-034 The bench SHALL cover the counter wrap: 256 handshakes on channel 4 -> cnt[31:24] returns to 0, other counters unchanged.
REQ-035 The bench SHALL cover channel isolation: channel 1 full and stalled, sel=11, di_valid=1 -> di_ready=1 and the word is delivered on do4 next cycle.
REQ-036 The bench SHALL cover reset mid-operation: all four channels full, rst=1 for one cycle with do_ready=1111 and di_valid=1 -> do_valid=0000, cnt=0, do1..do4=0 next cycle, di_ready=0 during rst, and di_ready=1 the cycle after.
